// File: rtl/axi_main.sv
// axi_main: AXI4 slave front end of the FIR accelerator; burst writes into
// the input-sample RAM, burst reads from the input or the output-sample RAM.
// Ports:
//   a_clk, a_rst_n          clock (rising edge), async active-low reset
//   aw*/w*/b*               write address, data and response channels
//   ar*/r*                  read address and data channels
// Word addressing: addr[12:0] is the RAM index, addr[13] selects
// RAM_wej (0) or RAM_wyj (1) on reads; writes always go to RAM_wej.

module axi_ram #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] adres,
    input  logic [DATA_W-1:0] din,
    input  logic              re,
    input  logic [ADDR_W-1:0] rd_adres,
    output logic [DATA_W-1:0] dout
);
    logic [DATA_W-1:0] pamiec_RAM [0:(1<<ADDR_W)-1];
    // dout only changes on a read request, so it stays stable while a beat waits for rready
    always_ff @(posedge clk) begin
        if (we) pamiec_RAM[adres] <= din;
        if (re) dout <= pamiec_RAM[rd_adres];
    end
endmodule

module axi_main #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 16,
    parameter int AXI_DW = 64
) (
    input  logic              a_clk,
    input  logic              a_rst_n,
    input  logic              awvalid,
    input  logic [31:0]       awaddr,
    input  logic [3:0]        awlen,
    input  logic [2:0]        awsize,
    input  logic [1:0]        awburst,
    output logic              awready,
    input  logic              wvalid,
    input  logic [AXI_DW-1:0] wdata,
    input  logic [7:0]        wstrb,
    input  logic              wlast,
    output logic              wready,
    output logic              bvalid,
    output logic [1:0]        bresp,
    input  logic              bready,
    input  logic              arvalid,
    input  logic [31:0]       araddr,
    input  logic [3:0]        arlen,
    input  logic [2:0]        arsize,
    input  logic [1:0]        arburst,
    output logic              arready,
    output logic              rvalid,
    output logic [AXI_DW-1:0] rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    input  logic              rready
);
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

    w_state_t          w_state, w_next;
    r_state_t          r_state, r_next;
    logic              live;
    logic [ADDR_W-1:0] w_adres;
    logic [3:0]        w_cnt;
    logic [ADDR_W:0]   r_addr;
    logic [3:0]        r_len, r_beat;
    logic [DATA_W-1:0] wej_dout, wyj_dout;
    logic              aw_hs, w_we, ar_hs, r_hs;
    logic              unused_ok;

    assign unused_ok = ^{awsize, awburst, wstrb, arsize, arburst, awaddr[31:ADDR_W],
                         araddr[31:ADDR_W+1], wdata[AXI_DW-1:DATA_W]};

    axi_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) RAM_wej (
        .clk(a_clk), .we(w_we), .adres(w_adres), .din(wdata[DATA_W-1:0]),
        .re(r_state == R_FETCH), .rd_adres(r_addr[ADDR_W-1:0]), .dout(wej_dout)
    );

    axi_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) RAM_wyj (
        .clk(a_clk), .we(1'b0), .adres('0), .din('0),
        .re(r_state == R_FETCH), .rd_adres(r_addr[ADDR_W-1:0]), .dout(wyj_dout)
    );

    // live holds the ready outputs low until the first edge after reset release
    always_ff @(posedge a_clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
            live    <= 1'b0;
            w_adres <= '0;
            w_cnt   <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_beat  <= '0;
        end else begin
            live    <= 1'b1;
            w_state <= w_next;
            r_state <= r_next;
            if (aw_hs) begin
                w_adres <= awaddr[ADDR_W-1:0];
                w_cnt   <= awlen;
            end else if (w_we) begin
                w_adres <= w_adres + 1'b1;
                w_cnt   <= w_cnt - 1'b1;
            end
            if (ar_hs) begin
                r_addr <= araddr[ADDR_W:0];
                r_len  <= arlen;
                r_beat <= '0;
            end else if (r_hs && !rlast) begin
                r_addr[ADDR_W-1:0] <= r_addr[ADDR_W-1:0] + 1'b1;
                r_beat             <= r_beat + 1'b1;
            end
        end
    end

    always_comb begin
        awready = live && w_state == W_IDLE;
        wready  = w_state == W_DATA;
        bvalid  = w_state == W_RESP;
        bresp   = 2'b00;
        aw_hs   = awvalid && awready;
        w_we    = wvalid && wready;
        w_next  = w_state;
        case (w_state)
            W_IDLE:  w_next = aw_hs ? W_DATA : W_IDLE;
            W_DATA:  w_next = (w_we && (w_cnt == 4'd0 || wlast)) ? W_RESP : W_DATA;
            W_RESP:  w_next = bready ? W_IDLE : W_RESP;
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        arready = live && r_state == R_IDLE;
        rvalid  = r_state == R_DATA;
        rlast   = rvalid && r_beat == r_len;
        rresp   = 2'b00;
        rdata   = rvalid ? {{(AXI_DW-DATA_W){1'b0}}, r_addr[ADDR_W] ? wyj_dout : wej_dout} : '0;
        ar_hs   = arvalid && arready;
        r_hs    = rvalid && rready;
        r_next  = r_state;
        case (r_state)
            R_IDLE:  r_next = ar_hs ? R_FETCH : R_IDLE;
            R_FETCH: r_next = R_DATA;
            R_DATA:  r_next = r_hs ? (rlast ? R_IDLE : R_FETCH) : R_DATA;
            default: r_next = R_IDLE;
        endcase
    end
endmodule

// File: tb/tb_axi_main.sv
// tb_axi_main: directed self-checking bench for axi_main.
module tb_axi_main;
    logic        a_clk = 1'b0;
    logic        a_rst_n = 1'b0;
    logic        awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0, bready = 1'b0;
    logic        arvalid = 1'b0, rready = 1'b0;
    logic [31:0] awaddr = '0, araddr = '0;
    logic [3:0]  awlen = '0, arlen = '0;
    logic [63:0] wdata = '0;
    logic        awready, wready, bvalid, arready, rvalid, rlast;
    logic [1:0]  bresp, rresp;
    logic [63:0] rdata;
    int          n_cmp = 0, n_bad = 0;

    always #5 a_clk = ~a_clk;

    axi_main dut (
        .a_clk(a_clk), .a_rst_n(a_rst_n),
        .awvalid(awvalid), .awaddr(awaddr), .awlen(awlen), .awsize(3'd1), .awburst(2'b01),
        .awready(awready), .wvalid(wvalid), .wdata(wdata), .wstrb(8'hFF), .wlast(wlast),
        .wready(wready), .bvalid(bvalid), .bresp(bresp), .bready(bready),
        .arvalid(arvalid), .araddr(araddr), .arlen(arlen), .arsize(3'd1), .arburst(2'b01),
        .arready(arready), .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rready(rready)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic wbeat(input logic [15:0] d, input logic last);
        wdata  = {48'h0, d};
        wvalid = 1'b1;
        wlast  = last;
        check("wready", wready, 1);
        @(negedge a_clk);
        wvalid = 1'b0;
        wlast  = 1'b0;
    endtask

    task automatic wait_rvalid();
        for (int n = 0; n < 10 && !rvalid; n++) @(negedge a_clk);
        check("rvalid_wait", rvalid, 1);
    endtask

    task automatic rbeat(input logic [15:0] exp, input logic exp_last);
        wait_rvalid();
        check("rdata", rdata, {48'h0, exp});
        check("rlast", rlast, exp_last);
        check("rresp", rresp, 0);
        rready = 1'b1;
        @(negedge a_clk);
        rready = 1'b0;
        check("rvalid_drop", rvalid, 0);
    endtask

    task automatic start_read(input logic [31:0] a, input logic [3:0] l);
        check("arready", arready, 1);
        araddr  = a;
        arlen   = l;
        arvalid = 1'b1;
        @(negedge a_clk);
        arvalid = 1'b0;
    endtask

    initial begin
        for (int i = 1; i <= 8; i++) dut.RAM_wyj.pamiec_RAM[i] = 16'(i);
        dut.RAM_wej.pamiec_RAM[13'h102] = 16'h5555;
        repeat (2) @(negedge a_clk);
        check("rst_outs", {awready, wready, bvalid, bresp, arready, rvalid, rresp, rlast}, 0);
        check("rst_rdata", rdata, 0);
        a_rst_n = 1'b1;
        @(negedge a_clk);
        check("awready_idle", awready, 1);
        check("arready_idle", arready, 1);

        awaddr  = 32'h0A;
        awlen   = 4'd2;
        awvalid = 1'b1;
        @(negedge a_clk);
        awvalid = 1'b0;
        check("awready_busy", awready, 0);
        wbeat(16'hABCD, 1'b0);
        wbeat(16'hFDDF, 1'b0);
        wbeat(16'hFAFA, 1'b1);
        check("wready_resp", wready, 0);
        check("bvalid", bvalid, 1);
        check("bresp", bresp, 0);
        @(negedge a_clk);
        check("bvalid_hold", bvalid, 1);
        bready = 1'b1;
        @(negedge a_clk);
        bready = 1'b0;
        check("bvalid_done", bvalid, 0);
        check("awready_back", awready, 1);
        check("ram_0a", dut.RAM_wej.pamiec_RAM[13'h0A], 16'hABCD);
        check("ram_0b", dut.RAM_wej.pamiec_RAM[13'h0B], 16'hFDDF);
        check("ram_0c", dut.RAM_wej.pamiec_RAM[13'h0C], 16'hFAFA);

        start_read(32'h2001, 4'd2);
        wait_rvalid();
        check("hold_data0", rdata, 64'h1);
        @(negedge a_clk);
        check("hold_valid", rvalid, 1);
        check("hold_data1", rdata, 64'h1);
        check("hold_last", rlast, 0);
        rbeat(16'h0001, 1'b0);
        rbeat(16'h0002, 1'b0);
        rbeat(16'h0003, 1'b1);
        check("arready_after", arready, 1);

        start_read(32'h000A, 4'd0);
        rbeat(16'hABCD, 1'b1);

        awaddr  = 32'h100;
        awlen   = 4'd3;
        awvalid = 1'b1;
        @(negedge a_clk);
        awvalid = 1'b0;
        wbeat(16'h1111, 1'b0);
        wbeat(16'h2222, 1'b1);
        check("early_wready", wready, 0);
        check("early_bvalid", bvalid, 1);
        bready = 1'b1;
        @(negedge a_clk);
        bready = 1'b0;
        check("early_100", dut.RAM_wej.pamiec_RAM[13'h100], 16'h1111);
        check("early_101", dut.RAM_wej.pamiec_RAM[13'h101], 16'h2222);
        check("early_102", dut.RAM_wej.pamiec_RAM[13'h102], 16'h5555);

        start_read(32'h000A, 4'd3);
        rbeat(16'hABCD, 1'b0);
        wait_rvalid();
        #2 a_rst_n = 1'b0;
        #1;
        check("arst_rvalid", rvalid, 0);
        check("arst_rdata", rdata, 0);
        check("arst_arready", arready, 0);
        @(negedge a_clk);
        a_rst_n = 1'b1;
        @(negedge a_clk);
        start_read(32'h000B, 4'd0);
        rbeat(16'hFDDF, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/axi_main.md
Name: axi_main

Overview:
- AXI4 slave front end of the FIR accelerator.
- Accepts burst writes of 16-bit samples into an internal input-sample RAM (instance RAM_wej).
- Serves burst reads from either the input RAM or an internal output-sample RAM (instance RAM_wyj).
- Each RAM is an array pamiec_RAM, 8192 x 16 bit. Benches access both RAMs hierarchically.

Parameters:
- ADDR_W, 13, RAM word-address width (depth 2^ADDR_W).
- DATA_W, 16, RAM word width.
- AXI_DW, 64, AXI data bus width.

Ports:
- a_clk  in  1  single system clock, rising edge.
- a_rst_n  in  1  reset, asynchronous, active-low.
- awvalid  in  1  write address valid.
- awaddr  in  32  write start word address.
- awlen  in  4  write beats minus 1.
- awsize  in  3  ignored.
- awburst  in  2  ignored; INCR assumed.
- awready  out  1  write address ready.
- wvalid  in  1  write data valid.
- wdata  in  64  write data; bits [15:0] used.
- wstrb  in  8  ignored; full word written.
- wlast  in  1  last write beat.
- wready  out  1  write data ready.
- bvalid  out  1  write response valid.
- bresp  out  2  always 2'b00 OKAY.
- bready  in  1  write response ready.
- arvalid  in  1  read address valid.
- araddr  in  32  read start word address.
- arlen  in  4  read beats minus 1.
- arsize  in  3  ignored.
- arburst  in  2  ignored; INCR.
- arready  out  1  read address ready.
- rvalid  out  1  read data valid.
- rdata  out  64  {48'b0, 16-bit word}.
- rresp  out  2  always 2'b00.
- rlast  out  1  last read beat.
- rready  in  1  read data ready.

Behaviour:
- Address map (word addressing): addr[12:0] is the RAM word index; addr[13] selects the RAM.
  - 0 = RAM_wej (input).
  - 1 = RAM_wyj (output).
  - addr[31:14] ignored.
- Writes always target RAM_wej (addr[13] ignored for writes).
- RAMs are not cleared by reset. Both are dual-port: one synchronous write port and one registered read port (1-cycle read latency).
- Write and read channels are independent FSMs and may run concurrently.
- Reset (a_rst_n low, async): all outputs 0, both FSMs forced to IDLE, internal counters and addresses cleared. Reset mid-burst aborts the burst with no response.
- Write FSM:
  - W_IDLE: awready=1 from the first clock edge after reset release.
  - On awvalid&&awready: latch addr[12:0] into RAM_wej.adres and latch awlen into the beat counter; go to W_DATA.
  - W_DATA: wready=1. Each cycle with wvalid high writes wdata[15:0] to RAM_wej[adres] at that clock edge, then adres++ (wraps at 8191->0).
  - Leave W_DATA after awlen+1 beats, or on a beat with wlast=1, whichever comes first; extra beats are not accepted.
  - W_RESP: bvalid=1, bresp=00, held until bready high on a clock edge; then W_IDLE.
- Read FSM:
  - R_IDLE: arready=1. On arvalid&&arready: latch araddr[13:0] and arlen; go to R_FETCH.
  - R_FETCH: issue RAM read (1 cycle); go to R_DATA.
  - R_DATA: rvalid=1, rdata=word, rlast=1 only on beat arlen, rresp=00. rdata/rlast held stable until rready.
  - On rvalid&&rready: if last beat go to R_IDLE, else address++ (13-bit wrap, RAM select bit unchanged) and go to R_FETCH.
  - rvalid deasserts the cycle after the handshake; a beat is never repeated or skipped.
- awlen=0 / arlen=0: single-beat burst, rlast set on that beat.

Test Plan:
- Reset: hold a_rst_n=0 for 2 cycles -> all outputs 0; after release awready=1 and arready=1.
- Write burst: awaddr=0x0A, awlen=2, then beats 0xABCD, 0xFDDF, 0xFAFA (wlast on 3rd) -> RAM_wej[0x0A..0x0C] = ABCD, FDDF, FAFA; bvalid=1, bresp=00 until bready pulse, then W_IDLE.
- Read output RAM: preload RAM_wyj[1..8]=1..8; araddr=0x2001, arlen=2; pulse rready per beat -> rdata 0x0001, 0x0002, 0x0003; rlast only on the 3rd beat; rvalid held while rready low.
- Read input RAM: araddr=0x000A, arlen=0 after the write test -> single beat rdata=0xABCD with rlast=1.
- Early wlast: awlen=3 with wlast on beat 2 -> only 2 words written, bvalid asserted.
- Async reset asserted mid read burst -> rvalid drops immediately; next arvalid is accepted normally.
